// File: rtl/seg7_operand_capture.sv
// Seven-segment operand capture: debounces 7-seg patterns, decodes them to
// hex digits, captures two operands f then g and pulses l for one cycle.
// Ports: c clock, r sync reset (active-high), s[6:0] pattern (a..g),
//        v pattern present, f/g operands, l load strobe, e invalid flag,
//        st state (0=WAIT_F, 1=WAIT_G, 2=LOAD).
module seg7_operand_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       c,
    input  logic       r,
    input  logic [6:0] s,
    input  logic       v,
    output logic [3:0] f,
    output logic [3:0] g,
    output logic       l,
    output logic       e,
    output logic [1:0] st
);

    typedef enum logic [1:0] {
        WAIT_F = 2'd0,
        WAIT_G = 2'd1,
        LOAD   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       last_q, last_d;
    logic             armed_q, armed_d;
    logic [3:0]       f_q, f_d;
    logic [3:0]       g_q, g_d;
    logic             l_q, l_d;
    logic             e_q, e_d;

    logic [3:0]       dig;
    logic             legal;
    logic             commit;

    always_comb begin
        dig   = 4'h0;
        legal = 1'b1;
        case (s)
            7'h3F: dig = 4'h0;
            7'h06: dig = 4'h1;
            7'h5B: dig = 4'h2;
            7'h4F: dig = 4'h3;
            7'h66: dig = 4'h4;
            7'h6D: dig = 4'h5;
            7'h7D: dig = 4'h6;
            7'h07: dig = 4'h7;
            7'h7F: dig = 4'h8;
            7'h6F: dig = 4'h9;
            7'h77: dig = 4'hA;
            7'h7C: dig = 4'hB;
            7'h39: dig = 4'hC;
            7'h5E: dig = 4'hD;
            7'h79: dig = 4'hE;
            7'h71: dig = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    // Stability counter saturates at CNT_MAX; a commit fires only on the
    // edge it reaches CNT_MAX while armed, and v=0 is the only re-arm.
    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        armed_d = armed_q;
        if (!v) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (s != last_q) begin
            cnt_d  = CNT_ONE;
            last_d = s;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
        commit = v && armed_q && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
        if (commit) begin
            armed_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        g_d     = g_q;
        e_d     = e_q;
        case (state_q)
            WAIT_F: begin
                if (commit && legal) begin
                    f_d     = dig;
                    e_d     = 1'b0;
                    state_d = WAIT_G;
                end else if (commit) begin
                    e_d = 1'b1;
                end
            end
            WAIT_G: begin
                if (commit && legal) begin
                    g_d     = dig;
                    e_d     = 1'b0;
                    state_d = LOAD;
                end else if (commit) begin
                    e_d = 1'b1;
                end
            end
            LOAD:    state_d = WAIT_F;
            default: state_d = WAIT_F;
        endcase
        // Registered from next state so l is high exactly while st=LOAD.
        l_d = (state_d == LOAD);
    end

    always_ff @(posedge c) begin
        if (r) begin
            state_q <= WAIT_F;
            cnt_q   <= '0;
            last_q  <= 7'h00;
            armed_q <= 1'b1;
            f_q     <= 4'h0;
            g_q     <= 4'h0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            f_q     <= f_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
        end
    end

    assign f  = f_q;
    assign g  = g_q;
    assign l  = l_q;
    assign e  = e_q;
    assign st = state_q;

endmodule
